// File: rtl/phase_ramp.sv
// Multi-channel polarity inverter: each channel crossfades its gain linearly
// between +1 and -1 over RAMP_LEN samples so live polarity flips do not click.
module phase_ramp #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int RAMP_LEN = 64
) (
    input  logic                      clk_48,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       phase,
    input  logic [CHANNELS*WIDTH-1:0] phaseIn,
    output logic [CHANNELS*WIDTH-1:0] phaseOut,
    output logic [CHANNELS-1:0]       ramp_busy
);
    localparam int L  = $clog2(RAMP_LEN);
    localparam int PW = WIDTH + L + 2;

    localparam logic [L:0]           CNT_MAX  = (L+1)'(RAMP_LEN);
    localparam logic [L:0]           CNT_ZERO = '0;
    localparam logic [L:0]           CNT_ONE  = {{L{1'b0}}, 1'b1};
    localparam logic signed [L+1:0]  K_MAX    = (L+2)'(RAMP_LEN);
    localparam logic signed [PW-1:0] SAT_MAX  = {{(L+3){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN  = {{(L+3){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE_POS  = 2'd0,
        RAMP_DOWN = 2'd1,
        IDLE_NEG  = 2'd2,
        RAMP_UP   = 2'd3
    } state_t;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_t                  state_q, state_d;
        logic [L:0]              cnt_q, cnt_d;
        logic signed [WIDTH-1:0] in_s;
        logic signed [WIDTH-1:0] out_q, out_d;
        logic signed [L+1:0]     k;
        logic signed [PW-1:0]    prod;
        logic signed [PW-1:0]    prod_sh;

        assign in_s = phaseIn[c*WIDTH +: WIDTH];

        // A reversal mid-ramp simply walks cnt back from where it is, keeping gain continuous.
        always_comb begin
            cnt_d   = cnt_q;
            state_d = state_q;
            if (phase[c] && (cnt_q != CNT_MAX)) begin
                cnt_d   = cnt_q + CNT_ONE;
                state_d = (cnt_d == CNT_MAX) ? IDLE_NEG : RAMP_DOWN;
            end else if (!phase[c] && (cnt_q != CNT_ZERO)) begin
                cnt_d   = cnt_q - CNT_ONE;
                state_d = (cnt_d == CNT_ZERO) ? IDLE_POS : RAMP_UP;
            end else begin
                state_d = (cnt_q == CNT_ZERO) ? IDLE_POS : IDLE_NEG;
            end
        end

        // k runs +RAMP_LEN..-RAMP_LEN; the >>> L floors, and only -min * -1 can overflow.
        always_comb begin
            k       = K_MAX - $signed({cnt_q, 1'b0});
            prod    = $signed({{(L+2){in_s[WIDTH-1]}}, in_s}) * $signed({{WIDTH{k[L+1]}}, k});
            prod_sh = prod >>> L;
            if (prod_sh > SAT_MAX) begin
                out_d = SAT_MAX[WIDTH-1:0];
            end else if (prod_sh < SAT_MIN) begin
                out_d = SAT_MIN[WIDTH-1:0];
            end else begin
                out_d = prod_sh[WIDTH-1:0];
            end
        end

        always_ff @(posedge clk_48 or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= IDLE_POS;
                cnt_q   <= '0;
                out_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
            end
        end

        assign phaseOut[c*WIDTH +: WIDTH] = out_q;
        assign ramp_busy[c]               = (state_q == RAMP_DOWN) || (state_q == RAMP_UP);
    end

endmodule

// File: tb/tb_phase_ramp.sv
// Directed self-checking bench for phase_ramp (4 channels, 16-bit, 64-sample ramp).
module tb_phase_ramp;
    localparam int W  = 16;
    localparam int CH = 4;
    localparam int RL = 64;

    logic          clk_48 = 1'b0;
    logic          reset_n;
    logic [CH-1:0] phase;
    logic [CH*W-1:0] phaseIn;
    logic [CH*W-1:0] phaseOut;
    logic [CH-1:0] ramp_busy;

    int checks = 0;
    int errors = 0;
    int sine [48];

    always #5 clk_48 = ~clk_48;

    phase_ramp #(.WIDTH(W), .CHANNELS(CH), .RAMP_LEN(RL)) dut (
        .clk_48   (clk_48),
        .reset_n  (reset_n),
        .phase    (phase),
        .phaseIn  (phaseIn),
        .phaseOut (phaseOut),
        .ramp_busy(ramp_busy)
    );

    function automatic int outCh(input int c);
        logic signed [W-1:0] v;
        v = phaseOut[c*W +: W];
        return int'(v);
    endfunction

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Drive one sample per channel, let one edge happen, land 1 ns after it.
    task automatic applyStimulus(input logic [CH-1:0] ph, input int i0, input int i1,
                                 input int i2, input int i3);
        phase   = ph;
        phaseIn = {i3[W-1:0], i2[W-1:0], i1[W-1:0], i0[W-1:0]};
        @(posedge clk_48);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expd);
        end
    endtask

    initial begin
        int busyCycles;
        int prev;
        int cntBefore;
        int o;
        int s;
        int in3;
        int maxStep;
        int expCnt [CH];
        logic [CH-1:0] ph;
        logic [CH-1:0] expBusy;

        for (int i = 0; i < 48; i++) begin
            real x;
            x = 32767.0 * $sin(2.0 * 3.14159265358979 * i / 48.0);
            sine[i] = $rtoi(x + ((x >= 0.0) ? 0.5 : -0.5));
        end
        maxStep = 0;
        for (int i = 0; i < 48; i++) begin
            if (absi(sine[(i + 1) % 48] - sine[i]) > maxStep) maxStep = absi(sine[(i + 1) % 48] - sine[i]);
        end

        // Reset with full-scale input present
        reset_n = 1'b0;
        phase   = '0;
        phaseIn = {CH{16'h7FFF}};
        #23;
        for (int c = 0; c < CH; c++) checkOutput($sformatf("reset_out%0d", c), outCh(c), 0);
        checkOutput("reset_busy", ramp_busy, 0);
        @(posedge clk_48);
        #1;
        reset_n = 1'b1;
        applyStimulus(4'b0000, 12539, 0, 0, 0);
        checkOutput("reset_release_out0", outCh(0), 12539);

        // Full ramp on channel 0: 16384 * (64-2*cnt)/64 = 16384 - 512*cnt
        busyCycles = 0;
        for (int j = 0; j < 66; j++) begin
            applyStimulus(4'b0001, 16384, 0, 0, 0);
            checkOutput($sformatf("ramp_out_e%0d", j), outCh(0), 16384 - 512 * ((j < RL) ? j : RL));
            checkOutput($sformatf("ramp_busy_e%0d", j), ramp_busy[0], (j <= RL - 2) ? 1 : 0);
            if (ramp_busy[0]) busyCycles++;
        end
        checkOutput("ramp_busy_len", busyCycles, 63);

        // Saturation in IDLE_NEG; channel 2 stays at unity gain
        applyStimulus(4'b0001, -32768, 0, -32768, 0);
        checkOutput("sat_neg_min", outCh(0), 32767);
        checkOutput("unity_min_ch2", outCh(2), -32768);
        applyStimulus(4'b0001, 32767, 0, 0, 0);
        checkOutput("sat_pos_max", outCh(0), -32767);
        checkOutput("sat_busy", ramp_busy, 0);

        // Reversal on channel 1 at cnt=20
        prev = 16384;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b0011, 16384, 16384, 0, 0);
            checkOutput($sformatf("rev_down_e%0d", i), outCh(1), 16384 - 512 * i);
            prev = outCh(1);
        end
        for (int i = 0; i < 22; i++) begin
            applyStimulus(4'b0001, 16384, 16384, 0, 0);
            cntBefore = (20 - i > 0) ? 20 - i : 0;
            checkOutput($sformatf("rev_up_e%0d", i), outCh(1), 16384 - 512 * cntBefore);
            checkOutput($sformatf("rev_step_e%0d", i), absi(outCh(1) - prev) <= 512, 1);
            checkOutput($sformatf("rev_busy_e%0d", i), ramp_busy[1], (i <= 18) ? 1 : 0);
            prev = outCh(1);
        end
        checkOutput("rev_ch0_held", outCh(0), -16384);

        // Multichannel: ch0 and ch2 toggle together, ch1 ten edges later, ch3 passes through
        expCnt = '{RL, 0, 0, 0};
        for (int t = 0; t < 80; t++) begin
            ph  = {1'b0, 1'b1, (t >= 10), 1'b0};
            in3 = t * 517 - 20000;
            applyStimulus(ph, 16384, 16384, 16384, in3);
            for (int c = 0; c < 3; c++) begin
                checkOutput($sformatf("mc_out%0d_e%0d", c, t), outCh(c), 16384 - 512 * expCnt[c]);
                if (ph[c] && expCnt[c] < RL) expCnt[c]++;
                else if (!ph[c] && expCnt[c] > 0) expCnt[c]--;
            end
            expBusy = '0;
            for (int c = 0; c < CH; c++) expBusy[c] = (expCnt[c] > 0) && (expCnt[c] < RL);
            checkOutput($sformatf("mc_out3_e%0d", t), outCh(3), in3);
            checkOutput($sformatf("mc_busy_e%0d", t), ramp_busy, expBusy);
        end

        // 1 kHz sine on channel 0, polarity request at sample 72 (1.5 ms)
        prev = outCh(0);
        for (int n = 0; n < 150; n++) begin
            s = sine[n % 48];
            applyStimulus((n >= 72) ? 4'b0001 : 4'b0000, s, 0, 0, 0);
            o = outCh(0);
            if (n <= 72) checkOutput($sformatf("sine_pass_e%0d", n), o, s);
            if (n >= 72 + RL) checkOutput($sformatf("sine_inv_e%0d", n), o, -s);
            if (n > 0) checkOutput($sformatf("sine_step_e%0d", n), absi(o - prev) <= maxStep + 1024, 1);
            prev = o;
        end

        // Reset asserted mid-ramp, then ramps restart from cnt=0
        for (int i = 0; i < 5; i++) applyStimulus(4'b0011, 1000, 16384, 0, 0);
        checkOutput("midramp_busy1", ramp_busy[1], 1);
        #2;
        reset_n = 1'b0;
        #1;
        for (int c = 0; c < CH; c++) checkOutput($sformatf("midreset_out%0d", c), outCh(c), 0);
        checkOutput("midreset_busy", ramp_busy, 0);
        @(posedge clk_48);
        #1;
        reset_n = 1'b1;
        applyStimulus(4'b0011, 1000, 16384, 0, 0);
        checkOutput("restart_out0", outCh(0), 1000);
        checkOutput("restart_out1", outCh(1), 16384);
        checkOutput("restart_busy", ramp_busy, 4'b0011);
        applyStimulus(4'b0011, 1000, 16384, 0, 0);
        checkOutput("restart_out1_e1", outCh(1), 15872);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
